// File: rtl/lbus_initiator.sv
// Local-bus initiator for the SURF board target: turns queued multi-beat requests
// into single-beat ADDR/DATA/TURN cycles and reports per-beat completion.
module lbus_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_BITS      = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [1:0]           req_space_i,
  input  logic [ADDR_BITS-1:0] req_addr_i,
  input  logic                 req_incr_i,
  input  logic [7:0]           req_count_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 wdata_ack_o,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_data_o,
  output logic                 rsp_last_o,
  output logic                 rsp_timeout_o,
  output logic                 busy_o,
  output logic                 nADS,
  output logic                 WnR,
  output logic [ADDR_BITS-1:0] LA,
  inout  wire  [31:0]          LD,
  output logic                 nCS2,
  output logic                 nCS3,
  output logic                 nRD,
  input  logic                 nREADY,
  input  logic                 nBTERM
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_TURN} state_t;
  state_t r_state, w_state_nxt;

  logic                 r_write, r_incr;
  logic [1:0]           r_space;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_cnt, r_tmo;
  logic                 r_nready_q, r_nbterm_q;
  logic [31:0]          r_ld_q, r_ld_out;
  logic                 r_ld_oe;
  logic                 w_rdy, w_tmo_hit, w_write_nxt, w_bus_nxt;
  logic [1:0]           w_space_nxt;
  logic [ADDR_BITS-1:0] w_addr_nxt;

  assign LD          = r_ld_oe ? r_ld_out : 32'bz;
  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nready_q <= 1'b1;
      r_nbterm_q <= 1'b1;
      r_ld_q     <= '0;
    end else begin
      r_nready_q <= nREADY;
      r_nbterm_q <= nBTERM;
      r_ld_q     <= LD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    // A ready sampled during ADDR lands in the first DATA cycle; ignore it there.
    w_rdy       = (r_state == S_DATA) && (r_tmo != 8'd0) && (!r_nready_q || !r_nbterm_q);
    w_tmo_hit   = (r_state == S_DATA) && !w_rdy && (r_tmo == 8'(TIMEOUT_CYCLES - 1));
    w_write_nxt = r_write;
    w_space_nxt = r_space;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        w_write_nxt = req_write_i;
        w_space_nxt = (req_space_i == 2'd3) ? 2'd0 : req_space_i;
        w_addr_nxt  = req_addr_i;
        if (req_valid_i) w_state_nxt = S_ADDR;
      end
      S_ADDR: w_state_nxt = S_DATA;
      S_DATA: if (w_rdy || w_tmo_hit) w_state_nxt = S_TURN;
      S_TURN: begin
        if (r_cnt != 8'd0) begin
          w_state_nxt = S_ADDR;
          w_addr_nxt  = r_addr + {{(ADDR_BITS-1){1'b0}}, r_incr};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_bus_nxt = (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA);
  end

  // Bus strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_write       <= 1'b0;
      r_incr        <= 1'b0;
      r_space       <= 2'd0;
      r_addr        <= '0;
      r_cnt         <= 8'd0;
      r_tmo         <= 8'd0;
      nADS          <= 1'b1;
      WnR           <= 1'b0;
      LA            <= '0;
      nCS2          <= 1'b1;
      nCS3          <= 1'b1;
      nRD           <= 1'b1;
      r_ld_oe       <= 1'b0;
      r_ld_out      <= '0;
      wdata_ack_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_last_o    <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_data_o    <= '0;
    end else begin
      r_write <= w_write_nxt;
      r_space <= w_space_nxt;
      r_addr  <= w_addr_nxt;
      if (r_state == S_IDLE) r_incr <= req_incr_i;
      r_tmo   <= (r_state == S_DATA) ? r_tmo + 8'd1 : 8'd0;
      if (r_state == S_IDLE)                      r_cnt <= req_count_i;
      else if (w_tmo_hit)                         r_cnt <= 8'd0;
      else if (r_state == S_TURN && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;

      nADS <= (w_state_nxt != S_ADDR);
      WnR  <= w_bus_nxt && w_write_nxt;
      if (w_state_nxt == S_ADDR) LA <= w_addr_nxt;
      nCS2 <= !(w_bus_nxt && (w_space_nxt == 2'd1));
      nCS3 <= !(w_bus_nxt && (w_space_nxt == 2'd2));
      nRD  <= !((w_state_nxt == S_DATA) && !w_write_nxt);
      r_ld_oe <= (w_state_nxt == S_DATA) && w_write_nxt;
      if (r_state == S_ADDR && r_write) r_ld_out <= req_wdata_i;
      wdata_ack_o <= (w_state_nxt == S_ADDR) && w_write_nxt;

      rsp_valid_o   <= w_rdy || w_tmo_hit;
      rsp_last_o    <= w_tmo_hit || (w_rdy && (r_cnt == 8'd0));
      rsp_timeout_o <= w_tmo_hit;
      if (w_rdy)          rsp_data_o <= r_write ? 32'd0 : r_ld_q;
      else if (w_tmo_hit) rsp_data_o <= 32'd0;
    end
  end
endmodule
